// File: rtl/rr_arb5_if.sv
// Handshake bundle between the five-source arbiter and its surroundings.
// The arbiter (master) drives the mux select, grant and valid; the
// environment (slave) drives the requests and the downstream handshake.
interface rr_arb5_if;
    logic [4:0] req;
    logic       last;
    logic       ready;
    logic       valid;
    logic [2:0] s;
    logic [4:0] grant;

    modport master (
        input  req,
        input  last,
        input  ready,
        output valid,
        output s,
        output grant
    );

    modport slave (
        output req,
        output last,
        output ready,
        input  valid,
        input  s,
        input  grant
    );
endinterface

// File: rtl/rr_arb5.sv
// Round-robin arbiter for five packet sources feeding a 5:1 mux.
// A grant is held for one packet: until a beat with last is accepted,
// the beat budget MAXBEATS is used up, or the owner withdraws its request.
// Every release is followed by exactly one arbitration cycle in IDLE.
module rr_arb5 #(
    parameter int MAXBEATS = 16
) (
    input  logic          clk,
    input  logic          rst,
    rr_arb5_if.master     bus
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t     r_state;
    logic [2:0] r_ptr;
    logic [2:0] r_s;
    logic [4:0] r_grant;
    logic       r_valid;
    logic [7:0] r_beats;

    state_t     w_stateNext;
    logic [2:0] w_ptrNext;
    logic [2:0] w_sNext;
    logic [4:0] w_grantNext;
    logic       w_validNext;
    logic [7:0] w_beatsNext;

    logic       w_found;
    logic [2:0] w_pick;
    logic [2:0] w_cand;
    logic       w_xfer;
    logic [7:0] w_beatsInc;

    // Search requests starting just after the last owner, wrapping 4 -> 0.
    always_comb begin
        w_found = 1'b0;
        w_pick  = 3'd0;
        w_cand  = 3'd0;
        for (int k = 1; k <= 5; k++) begin
            w_cand = 3'((int'(r_ptr) + k) % 5);
            if (!w_found && bus.req[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    // Next state and next registered outputs; release wins over counting.
    always_comb begin
        w_stateNext = r_state;
        w_ptrNext   = r_ptr;
        w_sNext     = r_s;
        w_grantNext = r_grant;
        w_validNext = r_valid;
        w_beatsNext = r_beats;
        w_xfer      = r_valid && bus.ready;
        w_beatsInc  = (r_beats == 8'(MAXBEATS)) ? r_beats : r_beats + 8'd1;

        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_stateNext = BUSY;
                    w_sNext     = w_pick;
                    w_grantNext = 5'd1 << w_pick;
                    w_validNext = 1'b1;
                    w_beatsNext = 8'd0;
                end else begin
                    w_validNext = 1'b0;
                    w_grantNext = 5'd0;
                end
            end
            BUSY: begin
                if (!bus.req[r_s]) begin
                    w_stateNext = IDLE;
                    w_ptrNext   = r_s;
                    w_validNext = 1'b0;
                    w_grantNext = 5'd0;
                end else if (w_xfer) begin
                    w_beatsNext = w_beatsInc;
                    if (bus.last || (w_beatsInc == 8'(MAXBEATS))) begin
                        w_stateNext = IDLE;
                        w_ptrNext   = r_s;
                        w_validNext = 1'b0;
                        w_grantNext = 5'd0;
                    end
                end
            end
            default: begin
                w_stateNext = IDLE;
                w_validNext = 1'b0;
                w_grantNext = 5'd0;
            end
        endcase
    end

    // State register; reset parks the pointer at 4 so source 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= 3'd4;
            r_s     <= 3'd0;
            r_grant <= 5'd0;
            r_valid <= 1'b0;
            r_beats <= 8'd0;
        end else begin
            r_state <= w_stateNext;
            r_ptr   <= w_ptrNext;
            r_s     <= w_sNext;
            r_grant <= w_grantNext;
            r_valid <= w_validNext;
            r_beats <= w_beatsNext;
        end
    end

    assign bus.valid = r_valid;
    assign bus.s     = r_s;
    assign bus.grant = r_grant;

endmodule
